// File: rtl/aes_gcm_pkg.sv
// Shared constants, phase codes and FSM state type for the AES-GCM block scheduler.
package aes_gcm_pkg;

    localparam int unsigned NUM_WORKERS = 4;
    localparam int unsigned MAX_BLOCKS  = 100000;
    localparam int unsigned BLOCK_BITS  = 128;
    localparam int unsigned BLK_SHIFT   = $clog2(BLOCK_BITS);
    localparam int unsigned IDX_W       = 17;

    localparam logic [2:0] PH_FIRST = 3'b000;
    localparam logic [2:0] PH_TEXT  = 3'b001;
    localparam logic [2:0] PH_AAD   = 3'b010;
    localparam logic [2:0] PH_LAST  = 3'b011;
    localparam logic [2:0] PH_IDLE  = 3'b100;
    localparam logic [2:0] PH_ONLY  = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StIssue
    } sched_state_e;

endpackage

// File: rtl/aes_gcm_phase_decode.sv
// Combinational phase code for a block index, given the AAD block count and frame size.
module aes_gcm_phase_decode
    import aes_gcm_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    input  logic [IDX_W-1:0] aad_blk_i,
    input  logic [IDX_W-1:0] total_i,
    output logic [2:0]       phase_o
);

    always_comb begin
        phase_o = PH_AAD;
        if (idx_i == total_i - IDX_W'(1)) begin
            // A frame with a single text block marks it as both first and last.
            phase_o = (total_i == aad_blk_i + IDX_W'(1)) ? PH_ONLY : PH_LAST;
        end else if (idx_i == aad_blk_i) begin
            phase_o = PH_FIRST;
        end else if (idx_i > aad_blk_i) begin
            phase_o = PH_TEXT;
        end
    end

endmodule

// File: rtl/aes_gcm_block_scheduler.sv
// Splits an AES-GCM frame into 128-bit blocks and hands them round-robin to the workers,
// one block per cycle, with strict index-to-worker routing.
module aes_gcm_block_scheduler #(
    parameter int unsigned NUM_WORKERS = aes_gcm_pkg::NUM_WORKERS,
    parameter int unsigned MAX_BLOCKS  = aes_gcm_pkg::MAX_BLOCKS
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    output logic                   o_start_ready,
    input  logic [63:0]            i_aad_bits,
    input  logic [63:0]            i_pt_bits,
    input  logic                   i_abort,
    input  logic [NUM_WORKERS-1:0] i_worker_ready,
    output logic [NUM_WORKERS-1:0] o_issue_valid,
    output logic [16:0]            o_block_idx,
    output logic [2:0]             o_phase,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err
);

    import aes_gcm_pkg::*;

    localparam int unsigned WSEL_W = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;

    sched_state_e      state_q, state_d;
    logic [63:0]       aad_q, aad_d;
    logic [63:0]       pt_q, pt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  total_q, total_d;
    logic [IDX_W-1:0]  aad_blk_q, aad_blk_d;
    logic [WSEL_W-1:0] wsel_q, wsel_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              issuing;
    logic              handshake;
    logic              last_blk;
    logic              len_bad;
    logic [64:0]       sum_bits;
    logic [64:0]       total_full;
    logic [2:0]        dec_phase;

    // 65-bit sum so a near-2^64 AAD plus plaintext is rejected rather than wrapping.
    assign sum_bits   = {1'b0, aad_q} + {1'b0, pt_q};
    assign total_full = sum_bits >> BLK_SHIFT;
    assign len_bad    = (|aad_q[BLK_SHIFT-1:0]) || (|pt_q[BLK_SHIFT-1:0]) ||
                        (pt_q == '0) || (total_full > 65'(MAX_BLOCKS));

    assign issuing  = (state_q == StIssue);
    assign last_blk = (idx_q == total_q - IDX_W'(1));

    // The worker pointer tracks idx mod NUM_WORKERS without a divider.
    always_comb begin
        o_issue_valid = '0;
        for (int unsigned w = 0; w < NUM_WORKERS; w++) begin
            o_issue_valid[w] = issuing && (wsel_q == WSEL_W'(w));
        end
    end

    assign handshake = |(o_issue_valid & i_worker_ready);

    aes_gcm_phase_decode u_phase_decode (
        .idx_i     (idx_q),
        .aad_blk_i (aad_blk_q),
        .total_i   (total_q),
        .phase_o   (dec_phase)
    );

    assign o_phase       = issuing ? dec_phase : PH_IDLE;
    assign o_block_idx   = issuing ? idx_q : '0;
    assign o_start_ready = (state_q == StIdle);
    assign o_busy        = (state_q != StIdle);
    assign o_done        = done_q;
    assign o_err         = err_q;

    always_comb begin
        state_d   = state_q;
        aad_d     = aad_q;
        pt_d      = pt_q;
        idx_d     = idx_q;
        total_d   = total_q;
        aad_blk_d = aad_blk_q;
        wsel_d    = wsel_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    aad_d   = i_aad_bits;
                    pt_d    = i_pt_bits;
                    state_d = StLoad;
                end
            end

            StLoad: begin
                if (i_abort) begin
                    state_d = StIdle;
                end else if (len_bad) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    total_d   = IDX_W'(total_full);
                    aad_blk_d = IDX_W'(aad_q >> BLK_SHIFT);
                    idx_d     = '0;
                    wsel_d    = '0;
                    state_d   = StIssue;
                end
            end

            StIssue: begin
                // Abort takes priority over a handshake in the same cycle.
                if (i_abort) begin
                    state_d = StIdle;
                    idx_d   = '0;
                    wsel_d  = '0;
                end else if (handshake) begin
                    if (last_blk) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        idx_d   = '0;
                        wsel_d  = '0;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        wsel_d = (wsel_q == WSEL_W'(NUM_WORKERS - 1)) ?
                                 '0 : wsel_q + WSEL_W'(1);
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            aad_q     <= '0;
            pt_q      <= '0;
            idx_q     <= '0;
            total_q   <= '0;
            aad_blk_q <= '0;
            wsel_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            aad_q     <= aad_d;
            pt_q      <= pt_d;
            idx_q     <= idx_d;
            total_q   <= total_d;
            aad_blk_q <= aad_blk_d;
            wsel_q    <= wsel_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule
